uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_sync.sv | 21 ++
 rtl/uart_rx.sv | 120 ++++++++++++
 tb/tb_uart_rx.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and FSM state type for the UART receiver slice.
package uart_pkg;

  localparam int UART_CLKS_PER_BIT = 5208;
  localparam int UART_DATA_W       = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_WAIT_HIGH
  } uart_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rxs
);

  logic [1:0] sync_ff;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_ff <= 2'b11;
    end else begin
      sync_ff <= {sync_ff[0], rx};
    end
  end

  assign rxs = sync_ff[1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 LSB-first UART receiver with a one-entry holding register and frame/overrun pulses.
// Handshake: a byte moves to the consumer on any clk edge where valid && ready are both high.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx,
  output logic [UART_DATA_W-1:0] data,
  output logic                   valid,
  input  logic                   ready,
  output logic                   frame_err,
  output logic                   overrun,
  output logic                   busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic                   rxs;
  uart_state_t            state;
  logic [CNT_W-1:0]       cnt;
  logic [2:0]             bit_idx;
  logic [UART_DATA_W-1:0] shreg;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .rx  (rx),
    .rxs (rxs)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_WAIT_HIGH;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      // Consumer take; a delivery later in this block may re-assert valid on the same edge.
      if (valid && ready) begin
        valid <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (!rxs) begin
            state <= ST_START;
            cnt   <= HALF_LOAD;
            busy  <= 1'b1;
          end
        end
        ST_START: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
          end else if (rxs) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            state   <= ST_DATA;
            cnt     <= FULL_LOAD;
            bit_idx <= '0;
          end
        end
        ST_DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
          end else begin
            shreg[bit_idx] <= rxs;
            cnt            <= FULL_LOAD;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        ST_STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_ONE;
          end else begin
            busy <= 1'b0;
            if (rxs) begin
              state <= ST_IDLE;
              if (!valid || ready) begin
                data  <= shreg;
                valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= ST_WAIT_HIGH;
            end
          end
        end
        ST_WAIT_HIGH: begin
          if (rxs) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_WAIT_HIGH;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: bit-accurate line driver, scoreboard on accepted bytes, pulse counters.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];

  int cyc = 0;
  int n_fe = 0;
  int n_ov = 0;
  int n_rise = 0;
  int n_vhi = 0;
  int n_extra = 0;
  int last_rise_cyc = 0;
  int fall_cyc = 0;
  logic valid_d = 1'b0;

  int fe0, ov0, rise0, vhi0;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .ready     (ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // monitor + scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (frame_err) n_fe++;
    if (overrun) n_ov++;
    if (valid) n_vhi++;
    if (valid && !valid_d) begin
      n_rise++;
      last_rise_cyc = cyc;
    end
    valid_d = valid;
    if (valid && ready) begin
      if (exp_q.size() > 0) check("accepted_data", {24'd0, data}, {24'd0, exp_q.pop_front()});
      else n_extra++;
    end
  end

  // driver tasks: inputs change 1 time unit after a rising edge
  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    fall_cyc = cyc;
    rx = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cyc(CPB);
    end
    rx = stop_bit;
    wait_cyc(CPB);
  endtask

  task automatic snap();
    fe0   = n_fe;
    ov0   = n_ov;
    rise0 = n_rise;
    vhi0  = n_vhi;
  endtask

  initial begin
    int lat;
    rst   = 1'b1;
    rx    = 1'b1;
    ready = 1'b0;
    wait_cyc(3);
    check("rst_data", {24'd0, data}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    wait_cyc(4);

    // single byte, consumer ready
    ready = 1'b1;
    snap();
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    wait_cyc(CPB);
    lat = last_rise_cyc - fall_cyc;
    check("a5_latency", (lat >= 154 && lat <= 156) ? 32'd155 : lat, 32'd155);
    check("a5_rises", n_rise - rise0, 1);
    check("a5_valid_cycles", n_vhi - vhi0, 1);
    check("a5_frame_err", n_fe - fe0, 0);
    check("a5_overrun", n_ov - ov0, 0);
    check("a5_pending", exp_q.size(), 0);

    // two bytes while consumer stalls: second dropped
    ready = 1'b0;
    snap();
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    wait_cyc(CPB);
    check("ovr_held_data", {24'd0, data}, 32'h3C);
    check("ovr_valid_held", {31'd0, valid}, 32'd1);
    check("ovr_pulses", n_ov - ov0, 1);
    ready = 1'b1;
    wait_cyc(2);
    check("ovr_valid_drop", {31'd0, valid}, 32'd0);
    check("ovr_rises", n_rise - rise0, 1);
    check("ovr_pending", exp_q.size(), 0);

    // short low glitch rejected
    snap();
    rx = 1'b0;
    wait_cyc(5);
    check("glitch_busy_hi", {31'd0, busy}, 32'd1);
    rx = 1'b1;
    wait_cyc(12);
    check("glitch_busy_lo", {31'd0, busy}, 32'd0);
    check("glitch_rises", n_rise - rise0, 0);
    check("glitch_frame_err", n_fe - fe0, 0);

    // bad stop bit followed by a long break
    snap();
    send_frame(8'h55, 1'b0);
    rx = 1'b0;
    wait_cyc(40 * CPB);
    rx = 1'b1;
    wait_cyc(CPB);
    check("brk_frame_err", n_fe - fe0, 1);
    check("brk_rises", n_rise - rise0, 0);
    snap();
    exp_q.push_back(8'h01);
    send_frame(8'h01, 1'b1);
    wait_cyc(CPB);
    check("brk_recover_rises", n_rise - rise0, 1);
    check("brk_recover_pending", exp_q.size(), 0);

    // reset in the middle of data bit 4 of 0xFF, released with the line low
    snap();
    rx = 1'b0;
    wait_cyc(CPB);
    rx = 1'b1;
    wait_cyc(4 * CPB + CPB / 2);
    rst = 1'b1;
    rx  = 1'b0;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(3);
    rx = 1'b1;
    wait_cyc(2 * CPB);
    check("rstmid_rises", n_rise - rise0, 0);
    check("rstmid_frame_err", n_fe - fe0, 0);
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    snap();
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    wait_cyc(CPB);
    check("rstmid_next_rises", n_rise - rise0, 1);
    check("rstmid_next_pending", exp_q.size(), 0);

    // back-to-back frames with no idle time
    snap();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    wait_cyc(CPB);
    check("b2b_rises", n_rise - rise0, 2);
    check("b2b_frame_err", n_fe - fe0, 0);
    check("b2b_overrun", n_ov - ov0, 0);
    check("b2b_pending", exp_q.size(), 0);

    check("extra_accepts", n_extra, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL timeout cyc=%0d", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
